// File: rtl/cpu_controller_if.sv
// Control bundle between the VeriRISC sequencer and its datapath: opcode/zero in,
// per-phase control strobes and debug phase out.
interface cpu_controller_if;
    logic [2:0] opcode;
    logic       zero;
    logic       sel;
    logic       rd;
    logic       wr;
    logic       ld_ir;
    logic       ld_ac;
    logic       ld_pc;
    logic       inc_pc;
    logic       data_e;
    logic       halt;
    logic [2:0] phase;

    modport master (
        input  opcode, zero,
        output sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase
    );

    modport slave (
        output opcode, zero,
        input  sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase
    );
endinterface

// File: rtl/cpu_controller.sv
// Eight-phase fetch/execute sequencer for VeriRISC; control lines are a pure
// decode of (phase, opcode, zero), with a sticky halt once HLT reaches OP_ADDR.
module cpu_controller (
    input  logic              clk,
    input  logic              rst,
    cpu_controller_if.master  bus
);
    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;

    typedef struct packed {
        logic sel;
        logic rd;
        logic wr;
        logic ld_ir;
        logic ld_ac;
        logic ld_pc;
        logic inc_pc;
        logic data_e;
        logic halt;
    } ctrl_t;

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;
    ctrl_t  ctrl;
    logic   alu_op;
    logic   is_hlt, is_skz, is_sto, is_jmp;

    assign is_hlt = (bus.opcode == HLT);
    assign is_skz = (bus.opcode == SKZ);
    assign is_sto = (bus.opcode == STO);
    assign is_jmp = (bus.opcode == JMP);
    assign alu_op = (bus.opcode == ADD) || (bus.opcode == AND) ||
                    (bus.opcode == XOR) || (bus.opcode == LDA);

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values; combinational blocks use blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Halt is sticky: once HLT is seen in OP_ADDR, only reset releases it.
    always_comb begin
        phase_d  = phase_e'(phase_q + 3'd1);
        halted_d = halted_q;
        if (halted_q) begin
            phase_d = phase_q;
        end else if (phase_q == OP_ADDR && is_hlt) begin
            phase_d  = OP_ADDR;
            halted_d = 1'b1;
        end
    end

    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        ctrl = '0;
        if (halted_q) begin
            ctrl.halt = 1'b1;
        end else begin
            unique case (phase_q)
                INST_ADDR: begin
                    ctrl.sel = 1'b1;
                end
                INST_FETCH: begin
                    ctrl.sel = 1'b1;
                    ctrl.rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    ctrl.sel   = 1'b1;
                    ctrl.rd    = 1'b1;
                    ctrl.ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    ctrl.halt   = is_hlt;
                    ctrl.inc_pc = !is_hlt;
                end
                OP_FETCH: begin
                    ctrl.rd = alu_op;
                end
                ALU_OP: begin
                    ctrl.rd     = alu_op;
                    ctrl.ld_ac  = alu_op;
                    ctrl.inc_pc = is_skz && bus.zero;
                    ctrl.ld_pc  = is_jmp;
                    ctrl.data_e = is_sto;
                end
                STORE: begin
                    ctrl.rd     = alu_op;
                    ctrl.ld_ac  = alu_op;
                    ctrl.inc_pc = is_jmp;
                    ctrl.ld_pc  = is_jmp;
                    ctrl.wr     = is_sto;
                    ctrl.data_e = is_sto;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign bus.sel    = ctrl.sel;
    assign bus.rd     = ctrl.rd;
    assign bus.wr     = ctrl.wr;
    assign bus.ld_ir  = ctrl.ld_ir;
    assign bus.ld_ac  = ctrl.ld_ac;
    assign bus.ld_pc  = ctrl.ld_pc;
    assign bus.inc_pc = ctrl.inc_pc;
    assign bus.data_e = ctrl.data_e;
    assign bus.halt   = ctrl.halt;
    assign bus.phase  = phase_q;
endmodule

// File: doc/cpu_controller.md
# cpu_controller

Eight-phase instruction sequencer for the VeriRISC CPU. It steps through a fixed fetch/execute cycle and, from the current phase, the decoded opcode and the accumulator zero flag, drives every datapath control line. These lines are the address mux select, memory read/write, IR/AC/PC loads, PC increment, data bus enable and halt. It is the only block that sequences the address `scale_mux`, the registers, the counter and the memory.

## Interface
- Parameters: none. Opcode width is fixed at 3 bits and there are fixed at 8 phases.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  3  instruction opcode from IR. Encodings: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- `zero`  in  1  accumulator-is-zero flag from the ALU.
- `sel`  out  1  address mux select: 1 = PC address, 0 = IR operand address.
- `rd`  out  1  memory read enable.
- `wr`  out  1  memory write strobe.
- `ld_ir`  out  1  IR load enable.
- `ld_ac`  out  1  accumulator load enable.
- `ld_pc`  out  1  PC load enable (jump).
- `inc_pc`  out  1  PC increment enable.
- `data_e`  out  1  accumulator-to-data-bus drive enable.
- `halt`  out  1  CPU halted indication.
- `phase`  out  3  current phase, for debug and verification.

## Operation
- State register: 3-bit phase with states INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7).
- Phase transitions:
  - Normal: advance +1 every clock, wrapping from STORE back to INST_ADDR.
  - Halt: exception in OP_ADDR when `opcode`==HLT (see halt behaviour below).
- ALUOP is defined as `opcode` ∈ {ADD, AND, XOR, LDA}.
- Outputs are combinational decode of (phase, opcode, zero). Any output not listed for a phase is 0.
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR: inc_pc=1, except when opcode==HLT, which gives halt=1 and inc_pc=0.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP, ld_ac=ALUOP, inc_pc=(SKZ & zero), ld_pc=JMP, data_e=STO.
  - STORE: rd=ALUOP, ld_ac=ALUOP, inc_pc=JMP, ld_pc=JMP, wr=STO, data_e=STO.
- Halt behaviour: in OP_ADDR with opcode==HLT, the phase holds at OP_ADDR and `halt` stays 1 on every following cycle until `rst`. While halted, all other outputs are 0, including inc_pc. `opcode` and `zero` are ignored while halted.
- Undefined phase values cannot occur (3-bit, fully decoded). The decode default drives all outputs to 0.
- `wr` is asserted only in STORE, so the memory write strobe is one cycle wide per STO instruction.

## Timing
- Reset: on `rst` high, `phase` goes to INST_ADDR immediately, without waiting for `clk`. While reset is held, outputs are sel=1 and all other controls 0.
- Reset deasserted: the first rising edge moves the phase to INST_FETCH.
- Reset mid-instruction, at any phase including halted: the phase returns to INST_ADDR asynchronously. No partial write is allowed: `wr` drops in the same delta as the phase change.
- Instruction latency: exactly 8 clocks per instruction, from INST_ADDR back to INST_ADDR.
- `opcode` sampling:
  - The value on INST_ADDR..INST_LOAD is don't-care.
  - It must be stable from IDLE through STORE (IR is loaded at INST_LOAD/IDLE).
- `zero` is only consulted in ALU_OP.
- Combinational outputs change only after a `clk` edge or an `rst` assertion. There is no output dependency on `opcode` in phases 0–3.

## Test plan
- Reset mid-cycle: drive 5 clocks, then assert `rst` between edges -> `phase`=0 without a clock edge, sel=1, all other outputs 0. Release `rst` -> after 1 edge phase=1, rd=1.
- ADD sequence: opcode=2, zero=0, run 8 clocks from phase 0 -> sel=1 for phases 0–3. Expected pulses:
  - rd high in phases 1,2,3,5,6,7.
  - ld_ir in phases 2,3.
  - inc_pc in phase 4.
  - ld_ac in phases 6,7.
  - wr, ld_pc, data_e never asserted.
- STO sequence: opcode=6 -> data_e=1 in phases 6,7. wr=1 only in phase 7. rd=0 and ld_ac=0 in phases 5–7.
- SKZ: opcode=1 with zero=1 -> inc_pc=1 in phases 4 and 6. Repeat with zero=0 -> inc_pc=1 only in phase 4.
- JMP: opcode=7 -> ld_pc=1 in phases 6,7. inc_pc=1 in phases 4,7.
- HLT: opcode=0 -> at phase 4, halt=1, and phase stays 4 for 20 further clocks with all other outputs 0. Assert `rst` -> phase=0 and halt=0 immediately.
